// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes them to instruction memory from word 0 up.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte after the data bytes.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [31:0]       mem_wd,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK = 3'd3,
`endif
        DONE  = 3'd4
    } state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CHECK;
`else
    localparam state_t AFTER_LOAD = DONE;
`endif

    localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] word_addr;
    logic [31:0]       word_reg;
    logic [1:0]        byte_idx;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_clamped;
    logic              start_ok;
    logic              accept;
    logic              last_word;
    logic              err_r;

    // Clamping the count keeps the last written address at 2^ADDR_W-1, so the address never wraps.
    assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
    assign start_ok      = start && ((state == IDLE) || (state == DONE));
    assign accept        = byte_valid && byte_ready;
    assign last_word     = ({1'b0, word_addr} == (count - COUNT_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: registers always take <= so every flop samples pre-edge values, independent of block order.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
        state_next = state;
        byte_ready = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        cpu_rst    = 1'b0;
        case (state)
            IDLE, DONE: begin
                cpu_rst = (state == DONE) && err_r;
                if (start) begin
                    state_next = (count_clamped == '0) ? AFTER_LOAD : RECV;
                end
            end
            RECV: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_rst    = 1'b1;
                if (byte_valid && (byte_idx == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                mem_we     = 1'b1;
                busy       = 1'b1;
                cpu_rst    = 1'b1;
                state_next = last_word ? AFTER_LOAD : RECV;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_rst    = 1'b1;
                if (byte_valid) begin
                    state_next = DONE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_addr <= '0;
            word_reg  <= '0;
            byte_idx  <= '0;
            count     <= '0;
        end else begin
            if (start_ok) begin
                count     <= count_clamped;
                word_addr <= '0;
                byte_idx  <= '0;
            end
            if ((state == RECV) && accept) begin
                case (byte_idx)
                    2'd0:    word_reg[31:24] <= byte_in;
                    2'd1:    word_reg[23:16] <= byte_in;
                    2'd2:    word_reg[15:8]  <= byte_in;
                    default: word_reg[7:0]   <= byte_in;
                endcase
                byte_idx <= byte_idx + 2'd1;
            end
            // The address stays on the last word rather than stepping past the end of memory.
            if ((state == WRITE) && !last_word) begin
                word_addr <= word_addr + ADDR_ONE;
            end
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            err_r <= 1'b0;
        end else begin
            if (start_ok) begin
                sum   <= '0;
                err_r <= 1'b0;
            end
            if ((state == RECV) && accept) begin
                sum <= sum + byte_in;
            end
            if ((state == CHECK) && accept) begin
                err_r <= (byte_in != sum);
            end
        end
    end
`else
    assign err_r = 1'b0;
`endif

    assign done   = (state == DONE);
    assign err    = err_r;
    assign mem_wa = word_addr;
    assign mem_wd = word_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: cycle vector table plus scoreboarded load sequences.
// Works with or without IMEM_LOADER_CHECKSUM_EN defined.
module tb_imem_loader;

    localparam int ADDR_W = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [31:0]       mem_wd;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_wa     (mem_wa),
        .mem_wd     (mem_wd),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic       start;
        logic       valid;
        logic [7:0] data;
        logic [5:0] exp;    // {byte_ready, mem_we, busy, cpu_rst, done, err}
    } vec_t;

    wr_t         sb [$];
    vec_t        vt [$];
    logic [31:0] prog [0:255];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          we_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Write-port monitor: every mem_we pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && mem_we) begin
            we_count++;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got wa=%0d wd=0x%08h, expected no write", mem_wa, mem_wd);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("write_addr", 32'(mem_wa), 32'(e.addr));
                check("write_data", mem_wd, e.data);
            end
        end
    end

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Runs one load of prog[0..] with a valid/ready handshake and checks timing, consumption and status.
    task automatic run_load(input string tag, input int n_req, input bit toggle, input int cks,
                            input int pulse_at, input int exp_done, input logic exp_err);
        logic [7:0] bytes [$];
        logic [7:0] sum;
        logic [7:0] b;
        int         n;
        int         ptr;
        int         cyc;
        int         budget;
        bit         rdy;
        bit         held;
        n   = (n_req > 256) ? 256 : n_req;
        sum = 8'h00;
        for (int i = 0; i < n; i++) begin
            sb.push_back('{addr: i[ADDR_W-1:0], data: prog[i]});
            for (int k = 3; k >= 0; k--) begin
                b = prog[i][8*k +: 8];
                bytes.push_back(b);
                sum = sum + b;
            end
        end
        b = (cks < 0) ? sum : cks[7:0];
`ifdef IMEM_LOADER_CHECKSUM_EN
        bytes.push_back(b);
`endif
        $display("load %s: %0d words, trailer 0x%02h", tag, n, b);
        start      = 1'b1;
        word_count = 9'(n_req);
        @(posedge clk);
        #1;
        start  = 1'b0;
        ptr    = 0;
        cyc    = 1;
        held   = 1'b1;
        budget = 12 * n + 30;
        while (!done && cyc < budget) begin
            if (!cpu_rst || !busy) held = 1'b0;
            start      = (cyc == pulse_at);
            word_count = (cyc == pulse_at) ? 9'd1 : 9'(n_req);
            byte_valid = (ptr < bytes.size()) && (!toggle || cyc[0]);
            byte_in    = (ptr < bytes.size()) ? bytes[ptr] : 8'h00;
            rdy        = byte_ready;
            @(posedge clk);
            #1;
            if (rdy && byte_valid) ptr++;
            cyc++;
        end
        start      = 1'b0;
        byte_valid = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        if (exp_done >= 0) check({tag, "_done_cycle"}, cyc, exp_done);
        check({tag, "_bytes_consumed"}, ptr, bytes.size());
        check({tag, "_writes_pending"}, sb.size(), 0);
        check({tag, "_cpu_rst_held"}, 32'(held), 32'd1);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_cpu_rst_final"}, 32'(cpu_rst), 32'(exp_err));
        check({tag, "_busy_final"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int  we0;
        int  ptr;
        int  cyc;
        bit  rdy;

        rst        = 1'b1;
        start      = 1'b0;
        word_count = '0;
        byte_in    = '0;
        byte_valid = 1'b0;
        #12;
        check("reset_ctrl", {26'd0, byte_ready, mem_we, busy, cpu_rst, done, err}, 32'd0);
        check("reset_wa", 32'(mem_wa), 32'd0);
        check("reset_wd", mem_wd, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cycle-by-cycle walk through a one-word load; the byte sent during WRITE must be ignored.
        vt.push_back('{1'b1, 1'b0, 8'h00, 6'b101100});
        vt.push_back('{1'b0, 1'b1, 8'hAA, 6'b101100});
        vt.push_back('{1'b0, 1'b0, 8'h00, 6'b101100});
        vt.push_back('{1'b0, 1'b1, 8'hBB, 6'b101100});
        vt.push_back('{1'b0, 1'b1, 8'hCC, 6'b101100});
        vt.push_back('{1'b0, 1'b1, 8'hDD, 6'b011100});
`ifdef IMEM_LOADER_CHECKSUM_EN
        vt.push_back('{1'b0, 1'b1, 8'hEE, 6'b101100});
        vt.push_back('{1'b0, 1'b1, 8'h0E, 6'b000010});
        vt.push_back('{1'b0, 1'b1, 8'hEE, 6'b000010});
`else
        vt.push_back('{1'b0, 1'b1, 8'hEE, 6'b000010});
        vt.push_back('{1'b0, 1'b1, 8'hEE, 6'b000010});
`endif
        sb.push_back('{addr: '0, data: 32'hAABBCCDD});
        word_count = 9'd1;
        for (int i = 0; i < vt.size(); i++) begin
            start      = vt[i].start;
            byte_valid = vt[i].valid;
            byte_in    = vt[i].data;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), {26'd0, byte_ready, mem_we, busy, cpu_rst, done, err},
                  {26'd0, vt[i].exp});
        end
        byte_valid = 1'b0;
        check("vec_writes_pending", sb.size(), 0);

        // Factorial program, valid held high.
        prog[0] = 32'h00008020; prog[1] = 32'h20100007; prog[2] = 32'h20110001;
        prog[3] = 32'h12000003; prog[4] = 32'h72308802; prog[5] = 32'h2210FFFF;
        prog[6] = 32'h08000003; prog[7] = 32'hAC110000; prog[8] = 32'h00000000;
        run_load("factorial", 9, 1'b0, -1, -1, 46 + CK, 1'b0);

        // Valid toggling every other cycle.
        prog[0] = 32'h12345678;
        prog[1] = 32'h9ABCDEF0;
        run_load("toggle", 2, 1'b1, -1, -1, -1, 1'b0);

        // Zero-length load from IDLE.
        pulse_rst();
        we0 = we_count;
        run_load("zero", 0, 1'b0, -1, -1, 1 + CK, 1'b0);
        check("zero_no_write", we_count - we0, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        prog[0] = 32'h01020304;
        run_load("cks_good", 1, 1'b0, 8'h0A, -1, 7, 1'b0);
        run_load("cks_bad", 1, 1'b0, 8'h0B, -1, 7, 1'b1);
        start      = 1'b1;
        word_count = 9'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_clears_err", 32'(err), 32'd0);
        check("restart_busy", 32'(busy), 32'd1);
`endif

        // Reset after the second of five words has been written.
        pulse_rst();
        for (int i = 0; i < 5; i++) prog[i] = $urandom;
        sb.push_back('{addr: 8'd0, data: prog[0]});
        sb.push_back('{addr: 8'd1, data: prog[1]});
        we0        = we_count;
        start      = 1'b1;
        word_count = 9'd5;
        @(posedge clk);
        #1;
        start      = 1'b0;
        ptr        = 0;
        cyc        = 0;
        byte_valid = 1'b1;
        while ((we_count - we0) < 2 && cyc < 40) begin
            byte_in = prog[ptr / 4][8 * (3 - ptr % 4) +: 8];
            rdy     = byte_ready;
            @(posedge clk);
            #1;
            if (rdy) ptr++;
            cyc++;
        end
        check("midrst_two_writes", we_count - we0, 2);
        rst = 1'b1;
        #1;
        check("midrst_ctrl", {26'd0, byte_ready, mem_we, busy, cpu_rst, done, err}, 32'd0);
        check("midrst_wa", 32'(mem_wa), 32'd0);
        check("midrst_wd", mem_wd, 32'd0);
        check("midrst_writes_pending", sb.size(), 0);
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // A start pulse (with a different count) in the middle of RECV must be ignored.
        run_load("busy_start", 2, 1'b0, -1, 3, 11 + CK, 1'b0);

        // 300 words requested, clamped to 256.
        for (int i = 0; i < 256; i++) prog[i] = $urandom;
        run_load("clamp", 300, 1'b0, -1, -1, 5 * 256 + 1 + CK, 1'b0);
        check("clamp_last_wa", 32'(mem_wa), 32'd255);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
